// File: rtl/mm_stream_param.sv
// Streaming signed matrix multiplier: loads A then B row-major,
// checks shape legality and emits saturated C = A x B elements.
module mm_stream_param #(
  parameter int DW   = 8,
  parameter int MAXD = 4,
  parameter int OW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 col_end,
  input  logic                 row_end,
  output logic                 busy,
  output logic                 is_legal,
  output logic                 valid,
  output logic signed [OW-1:0] out_data,
  output logic                 change_row,
  output logic                 overflow,
  output logic [1:0]           ep
);

  localparam int IW = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int CW = $clog2(MAXD + 2);
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + $clog2(MAXD);

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CHECK,
    CALC,
    EMIT,
    ERR,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] a_rows;
  logic [CW-1:0] a_cols;
  logic [CW-1:0] b_rows;
  logic [CW-1:0] b_cols;
  logic          ragged;
  logic          oversize;
  logic [1:0]    err_code;

  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] k;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [PW-1:0] prod;

  logic signed [DW-1:0] a_mem [MAXD][MAXD];
  logic signed [DW-1:0] b_mem [MAXD][MAXD];

  logic          last;
  logic [CW-1:0] len;
  logic [CW-1:0] row_cols;
  logic          store;
  logic [IW-1:0] row_i;
  logic [IW-1:0] col_i;

  logic          k_last;
  logic          j_last;
  logic          i_last;
  logic          dims_ok;

  logic signed [OW-1:0] sat_data;
  logic                 sat_hit;

  // A bare row_end still closes the row it ends.
  assign last     = col_end | row_end;
  assign len      = col + CW'(1);
  assign row_cols = (state == LOAD_B) ? b_cols : a_cols;
  assign row_i    = row[IW-1:0];
  assign col_i    = col[IW-1:0];

  assign store = in_valid
               && (state == LOAD_A || state == LOAD_B)
               && (row < CW'(MAXD))
               && (col < CW'(MAXD));

  assign prod     = a_mem[i][k] * b_mem[k][j];
  assign acc_next = acc + $signed({{(AW-PW){prod[PW-1]}}, prod});

  assign k_last  = (CW'(k) == a_cols - CW'(1));
  assign j_last  = (CW'(j) == b_cols - CW'(1));
  assign i_last  = (CW'(i) == a_rows - CW'(1));
  assign dims_ok = (a_cols == b_rows);

  always_comb begin
    sat_data = acc[OW-1:0];
    sat_hit  = 1'b0;
    if (acc > SMAX) begin
      sat_data = SMAX[OW-1:0];
      sat_hit  = 1'b1;
    end else if (acc < SMIN) begin
      sat_data = SMIN[OW-1:0];
      sat_hit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      if (state == LOAD_A) begin
        a_mem[row_i][col_i] <= in_data;
      end else begin
        b_mem[row_i][col_i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      row        <= '0;
      col        <= '0;
      a_rows     <= '0;
      a_cols     <= '0;
      b_rows     <= '0;
      b_cols     <= '0;
      ragged     <= 1'b0;
      oversize   <= 1'b0;
      err_code   <= 2'b00;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      is_legal   <= 1'b0;
      valid      <= 1'b0;
      out_data   <= '0;
      change_row <= 1'b0;
      overflow   <= 1'b0;
      ep         <= 2'b00;
    end else begin
      valid      <= 1'b0;
      change_row <= 1'b0;
      overflow   <= 1'b0;
      ep         <= 2'b00;
      unique case (state)
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            if (!last) begin
              // Column saturates at MAXD; excess elements are dropped.
              if (col < CW'(MAXD)) col <= len;
              if (len >= CW'(MAXD)) oversize <= 1'b1;
            end else begin
              col <= '0;
              if (row == '0) begin
                if (state == LOAD_A) a_cols <= len;
                else                 b_cols <= len;
              end else if (len != row_cols) begin
                ragged <= 1'b1;
              end
              if (!row_end) begin
                if (row < CW'(MAXD)) row <= row + CW'(1);
                if (row + CW'(1) >= CW'(MAXD)) oversize <= 1'b1;
              end else begin
                row <= '0;
                if (state == LOAD_A) begin
                  a_rows <= row + CW'(1);
                  state  <= LOAD_B;
                end else begin
                  b_rows <= row + CW'(1);
                  busy   <= 1'b1;
                  state  <= CHECK;
                end
              end
            end
          end
        end
        CHECK: begin
          is_legal <= dims_ok;
          i        <= '0;
          j        <= '0;
          k        <= '0;
          acc      <= '0;
          if (oversize) begin
            err_code <= 2'b11;
            state    <= ERR;
          end else if (ragged) begin
            err_code <= 2'b10;
            state    <= ERR;
          end else if (!dims_ok) begin
            err_code <= 2'b01;
            state    <= ERR;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (k_last) begin
            k     <= '0;
            state <= EMIT;
          end else begin
            k <= k + IW'(1);
          end
        end
        EMIT: begin
          valid      <= 1'b1;
          out_data   <= sat_data;
          overflow   <= sat_hit;
          change_row <= j_last;
          acc        <= '0;
          if (j_last) begin
            j <= '0;
            if (i_last) begin
              state <= DONE;
            end else begin
              i     <= i + IW'(1);
              state <= CALC;
            end
          end else begin
            j     <= j + IW'(1);
            state <= CALC;
          end
        end
        ERR: begin
          valid      <= 1'b1;
          ep         <= err_code;
          out_data   <= '0;
          change_row <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy     <= 1'b0;
          is_legal <= 1'b0;
          row      <= '0;
          col      <= '0;
          a_rows   <= '0;
          a_cols   <= '0;
          b_rows   <= '0;
          b_cols   <= '0;
          ragged   <= 1'b0;
          oversize <= 1'b0;
          err_code <= 2'b00;
          i        <= '0;
          j        <= '0;
          k        <= '0;
          acc      <= '0;
          state    <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_param.sv
// Directed table-driven bench for mm_stream_param with
// hand-written error, reset-abort and gap sequences.
module tb_mm_stream_param;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              col_end;
  logic              row_end;
  logic              busy;
  logic              is_legal;
  logic              valid;
  logic signed [11:0] out_data;
  logic              change_row;
  logic              overflow;
  logic [1:0]        ep;

  int n_chk;
  int n_fail;

  mm_stream_param #(.DW(8), .MAXD(4), .OW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .col_end    (col_end),
    .row_end    (row_end),
    .busy       (busy),
    .is_legal   (is_legal),
    .valid      (valid),
    .out_data   (out_data),
    .change_row (change_row),
    .overflow   (overflow),
    .ep         (ep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        am;
    logic [2:0]        ak;
    logic [2:0]        bk;
    logic [2:0]        bn;
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [1:0]        ep;
    logic [15:0][11:0] exp;
    logic [15:0]       ovf;
    logic              gap;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit ce, input bit re);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    col_end  = ce;
    row_end  = re;
  endtask

  // Idle cycle with garbage on the qualified lines.
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h7F;
    col_end  = 1'b1;
    row_end  = 1'b1;
  endtask

  task automatic load(input logic [15:0][7:0] m, input int r,
                      input int c, input bit gap);
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        send(m[rr*c+cc], cc == c-1, (rr == r-1) && (cc == c-1));
        if (gap && ((rr*c+cc) % 2 == 0) && !((rr == r-1) && (cc == c-1)))
          idle();
      end
    end
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int n;
    int np;
    int exp_n;
    int total;
    int kk;
    load(v.a, v.am, v.ak, v.gap);
    load(v.b, v.bk, v.bn, v.gap);
    @(negedge clk);
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
    n = 0;
    chk({tag, " busy_rise"}, busy, 1);
    kk    = v.ak;
    total = (v.ep != 0) ? 1 : v.am * v.bn;
    exp_n = (v.ep != 0) ? 2 : 2 + kk;
    np    = 0;
    while (np < total && n < 400) begin
      @(negedge clk);
      n++;
      if (valid) begin
        chk({tag, " pulse_time"}, n, exp_n);
        chk({tag, " out_data"}, $signed(out_data), $signed(v.exp[np]));
        chk({tag, " overflow"}, overflow, v.ovf[np]);
        chk({tag, " change_row"}, change_row,
            (v.ep != 0) || ((np % v.bn) == v.bn - 1));
        chk({tag, " ep"}, ep, v.ep);
        chk({tag, " is_legal"}, is_legal, v.ak == v.bk);
        np++;
        exp_n += kk + 1;
      end
      if (n == 1) begin
        chk({tag, " busy_hold"}, busy, 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        col_end  = 1'b1;
        row_end  = 1'b1;
      end else begin
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
      end
    end
    chk({tag, " pulse_count"}, np, total);
    @(negedge clk);
    chk({tag, " busy_fall"}, busy, 0);
  endtask

  task automatic finish_err(input logic [1:0] code, input string tag);
    int n;
    bit got;
    @(negedge clk);
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (valid) begin
        got = 1'b1;
        chk({tag, " err_time"}, n, 2);
        chk({tag, " err_ep"}, ep, code);
        chk({tag, " err_data"}, $signed(out_data), 0);
        chk({tag, " err_crow"}, change_row, 1);
        chk({tag, " err_ovf"}, overflow, 0);
      end
    end
    chk({tag, " err_seen"}, got, 1);
    @(negedge clk);
    chk({tag, " busy_fall"}, busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " is_legal"}, is_legal, 0);
    chk({tag, " valid"}, valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " change_row"}, change_row, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " ep"}, ep, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int q = 0; q < 10; q++) vt[q] = '0;

    // I2 x [[1,2],[3,4]] with idle gaps
    vt[0].am = 2; vt[0].ak = 2; vt[0].bk = 2; vt[0].bn = 2;
    vt[0].a[0] = 1; vt[0].a[3] = 1;
    vt[0].b[0] = 1; vt[0].b[1] = 2; vt[0].b[2] = 3; vt[0].b[3] = 4;
    vt[0].exp[0] = 1; vt[0].exp[1] = 2;
    vt[0].exp[2] = 3; vt[0].exp[3] = 4;
    vt[0].gap = 1'b1;

    // [-2,3] x [4;-5] = -23
    vt[1].am = 1; vt[1].ak = 2; vt[1].bk = 2; vt[1].bn = 1;
    vt[1].a[0] = -8'sd2; vt[1].a[1] = 8'sd3;
    vt[1].b[0] = 8'sd4;  vt[1].b[1] = -8'sd5;
    vt[1].exp[0] = -12'sd23;

    // 2x3 x 2x2: illegal dims
    vt[2].am = 2; vt[2].ak = 3; vt[2].bk = 2; vt[2].bn = 2;
    vt[2].ep = 2'b01;

    // 4x4 all 127 squared, and -128 x 127
    vt[3].am = 4; vt[3].ak = 4; vt[3].bk = 4; vt[3].bn = 4;
    vt[4].am = 4; vt[4].ak = 4; vt[4].bk = 4; vt[4].bn = 4;
    for (int q = 0; q < 16; q++) begin
      vt[3].a[q] = 8'd127; vt[3].b[q] = 8'd127;
      vt[3].exp[q] = 12'h7FF;
      vt[4].a[q] = 8'h80;  vt[4].b[q] = 8'd127;
      vt[4].exp[q] = 12'h800;
    end
    vt[3].ovf = 16'hFFFF;
    vt[4].ovf = 16'hFFFF;

    // [[1,-1],[2,3]] x [[2,0,1],[1,-1,4]]
    vt[5].am = 2; vt[5].ak = 2; vt[5].bk = 2; vt[5].bn = 3;
    vt[5].a[0] = 1; vt[5].a[1] = -8'sd1; vt[5].a[2] = 2; vt[5].a[3] = 3;
    vt[5].b[0] = 2; vt[5].b[1] = 0; vt[5].b[2] = 1;
    vt[5].b[3] = 1; vt[5].b[4] = -8'sd1; vt[5].b[5] = 4;
    vt[5].exp[0] = 1;  vt[5].exp[1] = 1;       vt[5].exp[2] = -12'sd3;
    vt[5].exp[3] = 7;  vt[5].exp[4] = -12'sd3; vt[5].exp[5] = 14;
    vt[5].gap = 1'b1;

    // outer product [1;2;-3] x [5,-6,7], K=1
    vt[6].am = 3; vt[6].ak = 1; vt[6].bk = 1; vt[6].bn = 3;
    vt[6].a[0] = 1; vt[6].a[1] = 2; vt[6].a[2] = -8'sd3;
    vt[6].b[0] = 5; vt[6].b[1] = -8'sd6; vt[6].b[2] = 7;
    vt[6].exp[0] = 5;         vt[6].exp[1] = -12'sd6; vt[6].exp[2] = 7;
    vt[6].exp[3] = 10;        vt[6].exp[4] = -12'sd12; vt[6].exp[5] = 14;
    vt[6].exp[6] = -12'sd15;  vt[6].exp[7] = 18;       vt[6].exp[8] = -12'sd21;

    // 3000 and -3000 clamp
    vt[7].am = 1; vt[7].ak = 3; vt[7].bk = 3; vt[7].bn = 1;
    vt[8].am = 1; vt[8].ak = 3; vt[8].bk = 3; vt[8].bn = 1;
    for (int q = 0; q < 3; q++) begin
      vt[7].a[q] = 8'd100;  vt[7].b[q] = 8'd10;
      vt[8].a[q] = -8'sd100; vt[8].b[q] = 8'd10;
    end
    vt[7].exp[0] = 12'h7FF; vt[7].ovf[0] = 1'b1;
    vt[8].exp[0] = 12'h800; vt[8].ovf[0] = 1'b1;

    // 1x1: 5 x 6
    vt[9].am = 1; vt[9].ak = 1; vt[9].bk = 1; vt[9].bn = 1;
    vt[9].a[0] = 5; vt[9].b[0] = 6; vt[9].exp[0] = 30;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    col_end  = 1'b0;
    row_end  = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    for (int q = 0; q < 10; q++) run_case(vt[q], $sformatf("vec%0d", q));

    // ragged: A rows of 2 then 3, B 3x1
    send(1, 0, 0); send(1, 1, 0);
    send(1, 0, 0); send(1, 0, 0); send(1, 1, 1);
    send(1, 1, 0); send(1, 1, 0); send(1, 1, 1);
    finish_err(2'b10, "ragged");

    // oversize row of 5, then a short row; oversize wins
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
    send(1, 0, 0); send(1, 1, 0);
    send(1, 0, 0); send(1, 1, 1);
    send(2, 1, 1);
    finish_err(2'b11, "oversize");

    // abort during CALC of the second element
    load(vt[0].a, 2, 2, 1'b0);
    load(vt[0].b, 2, 2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    col_end  = 1'b0;
    row_end  = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort first_valid", valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    run_case(vt[9], "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_stream_param.md
Name: mm_stream_param

Overview:
- Streaming signed matrix multiplier, parametrised successor of the fixed 4x4/8-bit MM engine in the Q-series datapath.
- Loads matrix A, then matrix B, as row-major element streams with row and matrix delimiters.
- Checks dimensional legality, then emits C = A x B one element per valid pulse, in row-major order.
- Adds input qualification, ragged/oversize error reporting, and saturating overflow detection.

Parameters:
- DW, 8, input element width (signed two's complement).
- MAXD, 4, maximum rows and columns of either matrix (storage MAXD*MAXD per matrix).
- OW, 12, output width (signed); results are saturated to this width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  qualifies in_data, col_end and row_end.
- in_data  input  DW  matrix element, signed.
- col_end  input  1  last element of the current row.
- row_end  input  1  last element of the current matrix; always asserted together with col_end.
- busy  output  1  block is checking/computing; input is ignored.
- is_legal  output  1  A columns == B rows; meaningful while busy.
- valid  output  1  one-cycle pulse; out_data/ep/overflow/change_row are valid.
- out_data  output  OW  result element, saturated.
- change_row  output  1  with valid: this element is the last of a C row.
- overflow  output  1  with valid: out_data was saturated.
- ep  output  2  error code with valid: 00 ok, 01 illegal dims, 10 ragged row, 11 oversize.

Behaviour:
- Reset: state LOAD_A; all counters, dimensions and error flags cleared; outputs busy, is_legal, valid, out_data, change_row, overflow, ep all 0. Reset mid-operation aborts immediately; no partial result is emitted.
- States: LOAD_A, LOAD_B, CHECK, CALC, EMIT, ERR, DONE.
- LOAD_A/LOAD_B: each in_valid cycle stores in_data at [row][col] and increments col.
  - On col_end: the first row latches the column count; col resets and row increments.
  - A later row whose length differs from the first row sets the sticky ragged flag.
  - col or row reaching MAXD without a delimiter sets the sticky oversize flag; excess elements are dropped.
  - in_valid && row_end moves LOAD_A to LOAD_B and LOAD_B to CHECK.
  - Cycles with in_valid=0 are ignored.
- CHECK (1 cycle): busy=1.
  - If oversize, then ragged, then A cols != B rows is true (that priority), go to ERR with code 11/10/01.
  - Otherwise go to CALC.
  - is_legal is registered from (A cols == B rows) here and held until DONE.
- CALC: K = A cols cycles. Each cycle adds sext(A[i][k]*B[k][j]) into an accumulator of width 2*DW+clog2(MAXD). The accumulator clears at the start of each element.
- EMIT (1 cycle): valid=1.
  - out_data = acc clamped to [-2^(OW-1), 2^(OW-1)-1]; overflow=1 iff clamped.
  - change_row=1 iff j = N-1 (N = B cols).
  - Advance j, then i. After element (M-1, N-1) go to DONE; otherwise return to CALC.
- Latency: with B row_end sampled at edge T, the first valid is high during cycle T+2+K. Successive valid pulses are K+1 cycles apart. Total pulses = M*N.
- ERR (1 cycle): valid=1, ep=code, out_data=0, overflow=0, change_row=1; then DONE.
- DONE (1 cycle): busy=0, is_legal=0, all counters and dims cleared; then LOAD_A. in_valid is ignored in DONE; the next A stream starts the following cycle.
- busy rises the cycle after the B row_end edge and falls in DONE. in_valid while busy is dropped with no side effects.
- valid, change_row, overflow and ep are 0 outside EMIT/ERR. out_data holds its last value.
- 1x1 matrices are legal (K=1). A K=MAXD accumulator cannot overflow internally; only the OW clamp saturates.

Test Plan:
- A=I2, B=[[1,2],[3,4]], DW=8, OW=12 -> four valid pulses: 1, 2 (change_row), 3, 4 (change_row); ep=00; overflow=0; pulses 3 cycles apart.
- A=[[-2,3]] (1x2), B=[[4],[-5]] -> single valid: out_data=-23, change_row=1, is_legal=1, ep=00.
- A 2x3, B 2x2 -> one valid cycle T+2: ep=01, is_legal=0, out_data=0; busy drops next cycle.
- A 4x4 all 127, B 4x4 all 127 -> 16 pulses, each out_data=2047, overflow=1. A all -128, B all 127 -> out_data=-2048, overflow=1.
- A rows of length 2 then 3 -> ep=10. A row of 5 elements with MAXD=4 -> ep=11 (oversize wins over ragged when both apply).
- Assert rst during CALC of the second element -> all outputs 0 the same cycle. A fresh 1x1 load (5 x 6) then yields out_data=30. Also verify in_valid=0 gaps during load and in_valid while busy do not alter results.
